// File: rtl/lamp_feedback_monitor_if.sv
// Lamp feedback monitor bus: check request, raw lamp sense and report handshake.
// master = requester/consumer side, slave = monitor side.
interface lamp_feedback_monitor_if;
  logic        start;
  logic [3:0]  cmd_num;
  logic [15:0] sense;
  logic        busy;
  logic        rpt_valid;
  logic        rpt_ready;
  logic [4:0]  sensed_num;
  logic        match;
  logic        timeout;
  logic [15:0] fault_map;

  modport master (
    output start, cmd_num, sense, rpt_ready,
    input  busy, rpt_valid, sensed_num, match, timeout, fault_map
  );

  modport slave (
    input  start, cmd_num, sense, rpt_ready,
    output busy, rpt_valid, sensed_num, match, timeout, fault_map
  );
endinterface

// File: rtl/lamp_feedback_monitor.sv
// Lamp feedback monitor: on start, waits for the lamps to settle, debounces the
// raw sense word, counts lit lamps serially and reports against the commanded
// thermometer pattern.
// Optional feature macro: LAMP_FAULT_MAP_EN (per-lamp mismatch bitmap).
module lamp_feedback_monitor #(
  parameter int SETTLE_CYC = 8,
  parameter int STABLE_CNT = 4,
  parameter int MAX_WAIT   = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  lamp_feedback_monitor_if.slave  mon
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SETTLE   = 3'd1;
  localparam logic [2:0] ST_DEBOUNCE = 3'd2;
  localparam logic [2:0] ST_COUNT    = 3'd3;
  localparam logic [2:0] ST_REPORT   = 3'd4;

  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYC - 1);
  localparam logic [15:0] STABLE_HIT  = 16'(STABLE_CNT);
  localparam logic [15:0] WAIT_LAST   = 16'(MAX_WAIT - 1);

  // Commanded pattern: lamps [n-1:0] on, n=0 means all off.
  function automatic logic [15:0] therm_pattern(input logic [3:0] n);
    therm_pattern = (16'h0001 << n) - 16'h0001;
  endfunction

  logic [2:0]  state_r;
  logic        busy_r;
  logic [3:0]  cmd_r;
  logic [15:0] cyc_cnt_r;
  logic [15:0] stab_r;
  logic [15:0] sample_r;
  logic [15:0] latch_r;
  logic        to_pend_r;
  logic [3:0]  bit_idx_r;
  logic [4:0]  acc_r;
  logic        rpt_valid_r;
  logic [4:0]  sensed_num_r;
  logic        match_r;
  logic        timeout_r;
  logic [15:0] stab_nxt_s;
  logic [15:0] cmd_pat_s;

  // Next stable-run length: first sample or a changed sample restarts the run.
  always_comb begin
    stab_nxt_s = ((stab_r == 16'd0) || (mon.sense != sample_r)) ? 16'd1 : (stab_r + 16'd1);
    cmd_pat_s  = therm_pattern(cmd_r);
  end

  // Check sequencer: settle, debounce, serial popcount, report handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      busy_r       <= 1'b0;
      cmd_r        <= 4'd0;
      cyc_cnt_r    <= 16'd0;
      stab_r       <= 16'd0;
      sample_r     <= 16'h0000;
      latch_r      <= 16'h0000;
      to_pend_r    <= 1'b0;
      bit_idx_r    <= 4'd0;
      acc_r        <= 5'd0;
      rpt_valid_r  <= 1'b0;
      sensed_num_r <= 5'd0;
      match_r      <= 1'b0;
      timeout_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (mon.start) begin
            cmd_r     <= mon.cmd_num;
            cyc_cnt_r <= 16'd0;
            busy_r    <= 1'b1;
            state_r   <= ST_SETTLE;
          end else begin
            busy_r <= 1'b0;
          end
        end
        ST_SETTLE: begin
          if (cyc_cnt_r == SETTLE_LAST) begin
            cyc_cnt_r <= 16'd0;
            stab_r    <= 16'd0;
            state_r   <= ST_DEBOUNCE;
          end else begin
            cyc_cnt_r <= cyc_cnt_r + 16'd1;
          end
        end
        ST_DEBOUNCE: begin
          sample_r  <= mon.sense;
          stab_r    <= stab_nxt_s;
          cyc_cnt_r <= cyc_cnt_r + 16'd1;
          // A converged sample wins over a simultaneous timeout.
          if (stab_nxt_s == STABLE_HIT) begin
            latch_r   <= mon.sense;
            to_pend_r <= 1'b0;
            bit_idx_r <= 4'd0;
            acc_r     <= 5'd0;
            state_r   <= ST_COUNT;
          end else if (cyc_cnt_r == WAIT_LAST) begin
            latch_r   <= mon.sense;
            to_pend_r <= 1'b1;
            bit_idx_r <= 4'd0;
            acc_r     <= 5'd0;
            state_r   <= ST_COUNT;
          end else begin
            state_r <= ST_DEBOUNCE;
          end
        end
        ST_COUNT: begin
          acc_r     <= acc_r + {4'b0000, latch_r[bit_idx_r]};
          bit_idx_r <= bit_idx_r + 4'd1;
          if (bit_idx_r == 4'd15) begin
            sensed_num_r <= acc_r + {4'b0000, latch_r[bit_idx_r]};
            match_r      <= (latch_r == cmd_pat_s) && !to_pend_r;
            timeout_r    <= to_pend_r;
            rpt_valid_r  <= 1'b1;
            state_r      <= ST_REPORT;
          end else begin
            state_r <= ST_COUNT;
          end
        end
        ST_REPORT: begin
          if (mon.rpt_ready) begin
            rpt_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            state_r     <= ST_IDLE;
          end else begin
            rpt_valid_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          busy_r      <= 1'b0;
          rpt_valid_r <= 1'b0;
        end
      endcase
    end
  end

`ifdef LAMP_FAULT_MAP_EN
  logic [15:0] fault_map_r;

  // Per-lamp mismatch bitmap, captured together with the report.
  always_ff @(posedge clk) begin
    if (rst) begin
      fault_map_r <= 16'h0000;
    end else if ((state_r == ST_COUNT) && (bit_idx_r == 4'd15)) begin
      fault_map_r <= latch_r ^ cmd_pat_s;
    end else begin
      fault_map_r <= fault_map_r;
    end
  end

  assign mon.fault_map = fault_map_r;
`else
  assign mon.fault_map = 16'h0000;
`endif

  assign mon.busy       = busy_r;
  assign mon.rpt_valid  = rpt_valid_r;
  assign mon.sensed_num = sensed_num_r;
  assign mon.match      = match_r;
  assign mon.timeout    = timeout_r;

endmodule

// File: tb/tb_lamp_feedback_monitor.sv
// Directed self-checking bench for lamp_feedback_monitor (default parameters).
// Fault-map expectations follow LAMP_FAULT_MAP_EN.
module tb_lamp_feedback_monitor;

  logic clk;
  logic rst;
  int   err_cnt;
  int   chk_cnt;
  logic toggle_en;
  int   lat;

  lamp_feedback_monitor_if mon_if ();

  lamp_feedback_monitor dut (
    .clk (clk),
    .rst (rst),
    .mon (mon_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value with its expectation.
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (toggle_en) mon_if.sense = (mon_if.sense == 16'h0001) ? 16'h0003 : 16'h0001;
  endtask

  // One-cycle start pulse; the edge that samples it counts as cycle 1.
  task automatic do_start(input logic [3:0] n);
    mon_if.cmd_num = n;
    mon_if.start   = 1'b1;
    tick();
    mon_if.start   = 1'b0;
  endtask

  // Wait (bounded) for rpt_valid, returning total cycles since start.
  task automatic wait_valid(input int from, input int max_cyc, output int n);
    n = from;
    while ((mon_if.rpt_valid !== 1'b1) && (n < max_cyc)) begin
      tick();
      n++;
    end
    check_val("rpt_valid_seen", {31'd0, mon_if.rpt_valid}, 32'd1);
  endtask

  initial begin
    logic stable_ok;
    err_cnt        = 0;
    chk_cnt        = 0;
    toggle_en      = 1'b0;
    rst            = 1'b1;
    mon_if.start   = 1'b0;
    mon_if.cmd_num = 4'd0;
    mon_if.sense   = 16'h0000;
    mon_if.rpt_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check_val("rst_busy",  {31'd0, mon_if.busy}, 32'd0);
    check_val("rst_valid", {31'd0, mon_if.rpt_valid}, 32'd0);
    check_val("rst_num",   {27'd0, mon_if.sensed_num}, 32'd0);
    check_val("rst_fault", {16'd0, mon_if.fault_map}, 32'd0);

    // cmd 5, five lamps lit: exact latency 29, clean match.
    mon_if.sense = 16'h001F;
    do_start(4'd5);
    check_val("t1_busy", {31'd0, mon_if.busy}, 32'd1);
    for (int i = 2; i <= 28; i++) tick();
    check_val("t1_valid_c28", {31'd0, mon_if.rpt_valid}, 32'd0);
    tick();
    check_val("t1_valid_c29", {31'd0, mon_if.rpt_valid}, 32'd1);
    check_val("t1_num",   {27'd0, mon_if.sensed_num}, 32'd5);
    check_val("t1_match", {31'd0, mon_if.match}, 32'd1);
    check_val("t1_tout",  {31'd0, mon_if.timeout}, 32'd0);
    check_val("t1_fault", {16'd0, mon_if.fault_map}, 32'd0);
    mon_if.rpt_ready = 1'b1;
    tick();
    mon_if.rpt_ready = 1'b0;
    check_val("t1_done_valid", {31'd0, mon_if.rpt_valid}, 32'd0);
    check_val("t1_done_busy",  {31'd0, mon_if.busy}, 32'd0);

    // cmd 3 vs sense 000B with ready held high throughout.
    mon_if.sense     = 16'h000B;
    mon_if.rpt_ready = 1'b1;
    do_start(4'd3);
    wait_valid(1, 200, lat);
    check_val("t2_lat",   lat, 32'd29);
    check_val("t2_num",   {27'd0, mon_if.sensed_num}, 32'd3);
    check_val("t2_match", {31'd0, mon_if.match}, 32'd0);
`ifdef LAMP_FAULT_MAP_EN
    check_val("t2_fault", {16'd0, mon_if.fault_map}, 32'h0000_000C);
`else
    check_val("t2_fault", {16'd0, mon_if.fault_map}, 32'h0000_0000);
`endif
    tick();
    mon_if.rpt_ready = 1'b0;
    check_val("t2_done_valid", {31'd0, mon_if.rpt_valid}, 32'd0);

    // Sense toggling every cycle never converges: timeout after 64 debounce cycles.
    mon_if.sense = 16'h0001;
    toggle_en    = 1'b1;
    do_start(4'd1);
    wait_valid(1, 300, lat);
    toggle_en = 1'b0;
    check_val("t3_lat",   lat, 32'd89);
    check_val("t3_tout",  {31'd0, mon_if.timeout}, 32'd1);
    check_val("t3_match", {31'd0, mon_if.match}, 32'd0);
    mon_if.rpt_ready = 1'b1;
    tick();
    mon_if.rpt_ready = 1'b0;

    // All 16 lamps lit vs cmd 15; report held 10 cycles, then start during completion ignored.
    mon_if.sense = 16'hFFFF;
    do_start(4'd15);
    wait_valid(1, 200, lat);
    check_val("t4_lat",   lat, 32'd29);
    check_val("t4_num",   {27'd0, mon_if.sensed_num}, 32'd16);
    check_val("t4_match", {31'd0, mon_if.match}, 32'd0);
    check_val("t4_tout",  {31'd0, mon_if.timeout}, 32'd0);
`ifdef LAMP_FAULT_MAP_EN
    check_val("t4_fault", {16'd0, mon_if.fault_map}, 32'h0000_8000);
`else
    check_val("t4_fault", {16'd0, mon_if.fault_map}, 32'h0000_0000);
`endif
    stable_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      mon_if.start = (i == 4);
      tick();
      if ((mon_if.rpt_valid !== 1'b1) || (mon_if.sensed_num !== 5'd16) ||
          (mon_if.match !== 1'b0) || (mon_if.timeout !== 1'b0)) stable_ok = 1'b0;
    end
    check_val("t4_hold", {31'd0, stable_ok}, 32'd1);
    mon_if.rpt_ready = 1'b1;
    mon_if.start     = 1'b1;
    tick();
    mon_if.rpt_ready = 1'b0;
    mon_if.start     = 1'b0;
    check_val("t4_idle_valid", {31'd0, mon_if.rpt_valid}, 32'd0);
    check_val("t4_idle_busy",  {31'd0, mon_if.busy}, 32'd0);
    tick();
    check_val("t4_start_ign",  {31'd0, mon_if.busy}, 32'd0);

    // Reset in COUNT aborts the check and clears the held report fields.
    mon_if.sense = 16'h001F;
    do_start(4'd5);
    for (int i = 2; i <= 16; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_val("t5_busy",  {31'd0, mon_if.busy}, 32'd0);
    check_val("t5_num",   {27'd0, mon_if.sensed_num}, 32'd0);
    check_val("t5_valid", {31'd0, mon_if.rpt_valid}, 32'd0);

    // Extra start while busy is ignored; then reset while report pending.
    do_start(4'd5);
    for (int i = 2; i <= 5; i++) tick();
    mon_if.start = 1'b1;
    tick();
    mon_if.start = 1'b0;
    wait_valid(6, 200, lat);
    check_val("t6_lat", lat, 32'd29);
    check_val("t6_match", {31'd0, mon_if.match}, 32'd1);
    rst              = 1'b1;
    mon_if.start     = 1'b1;
    mon_if.rpt_ready = 1'b1;
    tick();
    rst              = 1'b0;
    mon_if.start     = 1'b0;
    mon_if.rpt_ready = 1'b0;
    check_val("t6_valid", {31'd0, mon_if.rpt_valid}, 32'd0);
    check_val("t6_busy",  {31'd0, mon_if.busy}, 32'd0);
    check_val("t6_num",   {27'd0, mon_if.sensed_num}, 32'd0);
    check_val("t6_match", {31'd0, mon_if.match}, 32'd0);
    check_val("t6_tout",  {31'd0, mon_if.timeout}, 32'd0);
    check_val("t6_fault", {16'd0, mon_if.fault_map}, 32'd0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/lamp_feedback_monitor.md
LAMP_FEEDBACK_MONITOR -- requirements
Module: lamp_feedback_monitor

Interface
REQ-001 Parameter SETTLE_CYC, default 8: cycles waited after start before sampling.
REQ-002 Parameter STABLE_CNT, default 4: consecutive identical samples needed to accept sense.
REQ-003 Parameter MAX_WAIT, default 64: debounce cycle limit before timeout.
REQ-004 clk  in  1  rising-edge clock; the block's only clock.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start  in  1  request one check; accepted only in IDLE.
REQ-007 cmd_num  in  4  commanded active-lamp count (0..15).
REQ-008 sense  in  16  raw lamp-on feedback, bit i = lamp i lit; asynchronous to the check.
REQ-009 busy  out  1  high in every state except IDLE.
REQ-010 rpt_valid  out  1  report available.
REQ-011 rpt_ready  in  1  consumer accepts report.
REQ-012 sensed_num  out  5  count of lit lamps (0..16).
REQ-013 match  out  1  sensed pattern equals commanded pattern.
REQ-014 timeout  out  1  debounce did not converge.
REQ-015 fault_map  out  16  per-lamp mismatch bitmap (see Configuration).

Function
REQ-016 Commanded pattern SHALL be thermometer: bits [cmd_num-1:0] set, others clear; cmd_num=0 -> all clear; bit 15 never expected.
REQ-017 FSM states SHALL be IDLE, SETTLE, DEBOUNCE, COUNT, REPORT.
REQ-018 IDLE with start=1 SHALL latch cmd_num and go to SETTLE next cycle; start in any other state SHALL be ignored.
REQ-019 SETTLE SHALL last exactly SETTLE_CYC cycles, then go to DEBOUNCE.
REQ-020 DEBOUNCE SHALL register sense each cycle; stable counter increments when sample equals previous, else reloads to 1; reaching STABLE_CNT latches the sample and goes to COUNT.
REQ-021 If MAX_WAIT DEBOUNCE cycles elapse first, the last sample SHALL be latched, timeout set, and COUNT entered.
REQ-022 COUNT SHALL popcount the latched sample one bit per cycle, bit 0 first, taking exactly 16 cycles, then go to REPORT.
REQ-023 sensed_num, match, timeout, fault_map SHALL be updated on REPORT entry and held stable while rpt_valid=1.
REQ-024 REPORT SHALL hold rpt_valid=1 until a cycle with rpt_ready=1; that cycle completes the transfer and next state is IDLE with rpt_valid=0.
REQ-025 rpt_ready while rpt_valid=0 SHALL have no effect.
REQ-026 Minimum start-to-rpt_valid latency with sense constant: 1+SETTLE_CYC+STABLE_CNT+16 cycles (29 at defaults).
REQ-027 match SHALL be 1 iff latched sample equals commanded pattern exactly and timeout=0.
REQ-028 start asserted in the same cycle a report completes SHALL be ignored; a new check requires start in IDLE.

Reset
REQ-029 rst=1 SHALL, at the next clk edge, force IDLE and clear busy, rpt_valid, sensed_num, match, timeout, fault_map, and all counters.
REQ-030 rst asserted mid-check (any state, including REPORT with rpt_valid=1) SHALL abort it; the pending report is discarded.
REQ-031 rst SHALL take priority over start and rpt_ready in the same cycle.

Configuration
REQ-032 Macro LAMP_FAULT_MAP_EN defined: fault_map SHALL equal latched sample XOR commanded pattern, updated per REQ-023.
REQ-033 Macro LAMP_FAULT_MAP_EN undefined: fault_map SHALL be constant 0 and no per-lamp comparison logic SHALL be built; all other behaviour unchanged.

Verification
REQ-034 Reset, cmd_num=5, sense=16'h001F held, start pulse -> rpt_valid at cycle 29, sensed_num=5, match=1, timeout=0, fault_map=0.
REQ-035 cmd_num=3, sense=16'h000B, rpt_ready=1 -> sensed_num=3, match=0, fault_map=16'h000C with LAMP_FAULT_MAP_EN, 0 without.
REQ-036 sense toggling 16'h0001/16'h0003 every cycle -> timeout=1, match=0, rpt_valid after 1+8+64+16=89 cycles.
REQ-037 sense=16'hFFFF, cmd_num=15, rpt_ready low 10 cycles -> sensed_num=16, match=0, outputs stable 10 cycles, IDLE one cycle after rpt_ready.
REQ-038 rst pulsed in COUNT, then in REPORT with rpt_valid=1 -> all outputs 0 next cycle, busy=0; start during busy ignored.
